// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// status widths and the sizing rule for the shared down-counter.
package pll_seq_pkg;

   localparam int STATE_W = 3;
   localparam int COUNT_W = 8;

   // Encodings are visible on the debug port, so they are fixed explicitly.
   typedef enum logic [STATE_W-1:0] {
      ST_PLL_RESET = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_HOLD      = 3'd3,
      ST_RUN       = 3'd4
   } state_t;

   // The counter is loaded with (cycles - 1), so $clog2 of the largest
   // interval is enough bits. Never narrower than one bit.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Output lags the input by two clock edges; both flops clear on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the asynchronous input through two flops to resolve metastability.
   // NOTE: non-blocking assignments make meta and q sample their inputs at the
   // same edge; blocking here would collapse the chain into a single flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with a timeout,
// qualifies lock over a stable window, then holds the core in reset for a
// release interval before entering RUN. One down-counter times every state
// and reloads whenever a state is entered.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 1048576,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int RELEASE_CYCLES      = 256
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                pll_locked,
   input  logic                soft_reset_req,
   output logic                pll_rst,
   output logic                sys_reset,
   output logic                ready,
   output logic [COUNT_W-1:0]  lock_loss_count,
   output logic                timeout_flag,
   output logic [STATE_W-1:0]  state
);

   localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                    LOCK_STABLE_CYCLES, RELEASE_CYCLES);

   // Each load is (interval - 1): the state exits on the cycle the counter
   // reads zero, giving exactly 'interval' cycles of residence.
   localparam logic [CNT_W-1:0] LOAD_PLL_RESET = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_TIMEOUT   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_STABLE    = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_RELEASE   = CNT_W'(RELEASE_CYCLES - 1);

   localparam logic [COUNT_W-1:0] LOSS_MAX = {COUNT_W{1'b1}};

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [COUNT_W-1:0] loss_d;
   logic               timeout_d;
   logic               pll_rst_d;
   logic               sys_reset_d;
   logic               ready_d;
   logic               lk;
   logic               cnt_zero;

   // Counter value to load when a state is entered. RUN is untimed.
   function automatic logic [CNT_W-1:0] load_for(input state_t s);
      case (s)
         ST_PLL_RESET: return LOAD_PLL_RESET;
         ST_WAIT_LOCK: return LOAD_TIMEOUT;
         ST_STABILIZE: return LOAD_STABLE;
         ST_HOLD:      return LOAD_RELEASE;
         default:      return '0;
      endcase
   endfunction

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk)
   );

   assign cnt_zero = (cnt_q == '0);
   assign state    = state_q;

   // Next-state, counter and status logic; outputs are derived from the
   // next state so that the registered outputs line up with the state register.
   // NOTE: every variable gets a default before the case so that no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      loss_d    = lock_loss_count;
      timeout_d = timeout_flag;

      unique case (state_q)
         ST_PLL_RESET: begin
            if (cnt_zero) state_d = ST_WAIT_LOCK;
            else          cnt_d   = cnt_q - 1'b1;
         end

         // Lock on the last allowed cycle wins over the timeout.
         ST_WAIT_LOCK: begin
            if (lk) begin
               state_d = ST_STABILIZE;
            end else if (cnt_zero) begin
               state_d   = ST_PLL_RESET;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         // Any low cycle breaks the run of consecutive locked cycles.
         ST_STABILIZE: begin
            if (!lk)           state_d = ST_WAIT_LOCK;
            else if (cnt_zero) state_d = ST_HOLD;
            else               cnt_d   = cnt_q - 1'b1;
         end

         // Lock dropping before release is not a loss seen in RUN.
         ST_HOLD: begin
            if (!lk)           state_d = ST_WAIT_LOCK;
            else if (cnt_zero) state_d = ST_RUN;
            else               cnt_d   = cnt_q - 1'b1;
         end

         // Lock loss outranks a simultaneous soft reset request.
         ST_RUN: begin
            if (!lk) begin
               state_d = ST_PLL_RESET;
               if (lock_loss_count != LOSS_MAX) loss_d = lock_loss_count + 1'b1;
            end else if (soft_reset_req) begin
               state_d = ST_HOLD;
            end
         end

         default: state_d = ST_PLL_RESET;
      endcase

      // Fresh interval on every entry, including RUN -> HOLD on soft reset.
      if (state_d != state_q) cnt_d = load_for(state_d);

      pll_rst_d   = (state_d == ST_PLL_RESET);
      ready_d     = (state_d == ST_RUN);
      sys_reset_d = !ready_d;
   end

   // State, counter and all outputs; reset aborts any state at once and
   // preloads a full PLL reset interval.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_PLL_RESET;
         cnt_q           <= LOAD_PLL_RESET;
         pll_rst         <= 1'b1;
         sys_reset       <= 1'b1;
         ready           <= 1'b0;
         lock_loss_count <= '0;
         timeout_flag    <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         pll_rst         <= pll_rst_d;
         sys_reset       <= sys_reset_d;
         ready           <= ready_d;
         lock_loss_count <= loss_d;
         timeout_flag    <= timeout_d;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small intervals.
// A cycle-level reference model (lock history array plus elapsed-cycle
// bookkeeping) predicts every output after every clock edge; directed
// scenarios add explicit timing checks, then a randomized phase follows.
module tb_pll_reset_sequencer;

   localparam int PRC = 4;
   localparam int TO  = 64;
   localparam int LS  = 8;
   localparam int RC  = 4;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       soft_reset_req = 1'b0;
   logic       pll_rst;
   logic       sys_reset;
   logic       ready;
   logic [7:0] lock_loss_count;
   logic       timeout_flag;
   logic [2:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase numbers are the documented debug encodings.
   int m_state;
   int m_elapsed;
   int m_loss;
   bit m_to;
   bit lock_hist [2];

   always #5 refclk = ~refclk;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES      (PRC),
      .LOCK_TIMEOUT_CYCLES (TO),
      .LOCK_STABLE_CYCLES  (LS),
      .RELEASE_CYCLES      (RC)
   ) dut (
      .refclk          (refclk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .soft_reset_req  (soft_reset_req),
      .pll_rst         (pll_rst),
      .sys_reset       (sys_reset),
      .ready           (ready),
      .lock_loss_count (lock_loss_count),
      .timeout_flag    (timeout_flag),
      .state           (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state     = 0;
      m_elapsed   = 0;
      m_loss      = 0;
      m_to        = 1'b0;
      lock_hist[0] = 1'b0;
      lock_hist[1] = 1'b0;
   endtask

   task automatic enter(input int s);
      m_state   = s;
      m_elapsed = 0;
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_step();
      bit lk;
      lk           = lock_hist[1];
      lock_hist[1] = lock_hist[0];
      lock_hist[0] = pll_locked;
      case (m_state)
         0: begin
            m_elapsed++;
            if (m_elapsed == PRC) enter(1);
         end
         1: begin
            if (lk) enter(2);
            else begin
               m_elapsed++;
               if (m_elapsed == TO) begin
                  m_to = 1'b1;
                  enter(0);
               end
            end
         end
         2: begin
            if (!lk) enter(1);
            else begin
               m_elapsed++;
               if (m_elapsed == LS) enter(3);
            end
         end
         3: begin
            if (!lk) enter(1);
            else begin
               m_elapsed++;
               if (m_elapsed == RC) enter(4);
            end
         end
         default: begin
            if (!lk) begin
               if (m_loss < 255) m_loss++;
               enter(0);
            end else if (soft_reset_req) begin
               enter(3);
            end
         end
      endcase
   endtask

   function automatic logic [14:0] got_vec();
      return {state, pll_rst, sys_reset, ready, timeout_flag, lock_loss_count};
   endfunction

   function automatic logic [14:0] exp_vec();
      logic [2:0] s;
      logic [7:0] l;
      s = 3'(m_state);
      l = 8'(m_loss);
      return {s, (m_state == 0), (m_state != 4), (m_state == 4), m_to, l};
   endfunction

   task automatic check_outs(input string tag);
      check(tag, 32'(got_vec()), 32'(exp_vec()));
   endtask

   // Advance one clock; model steps on the edge, outputs sampled on the falling edge.
   task automatic tick();
      @(posedge refclk);
      model_step();
      @(negedge refclk);
      check_outs("outs");
   endtask

   task automatic do_reset(input int hold);
      @(negedge refclk);
      rst = 1'b1;
      #1;
      model_reset();
      check_outs("reset_outs");
      repeat (hold) begin
         @(negedge refclk);
         check_outs("reset_hold");
      end
      rst = 1'b0;
   endtask

   task automatic wait_state(input int s, input int bound, input string tag);
      int n;
      n = 0;
      while (state !== 3'(s) && n < bound) begin
         tick();
         n++;
      end
      check(tag, 32'(state), 32'(s));
   endtask

   // Assert reset just after a falling edge, well before the next rising edge.
   task automatic async_reset_in(input int s, input string tag);
      pll_locked = 1'b1;
      wait_state(s, 300, {tag, "_reach"});
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_outs(tag);
      @(negedge refclk);
      check_outs({tag, "_hold"});
      rst = 1'b0;
   endtask

   initial begin : main
      int n;
      int cnt;
      int first_low;
      int first_to;
      int last_rise;
      int bad_period;
      int ready_seen;
      int loss_before;
      logic prev_pll;
      int hold_left;

      model_reset();

      // Nominal bring-up: lock appears at cycle 10 and stays.
      do_reset(2);
      pll_locked = 1'b0;
      cnt = 0;
      first_low = -1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         if (pll_rst === 1'b1) cnt++;
         else if (first_low < 0) first_low = i;
      end
      check("nom_pll_rst_cycles", 32'(cnt), 32'(PRC));
      check("nom_pll_rst_first_low", 32'(first_low), 32'(PRC));
      pll_locked = 1'b1;
      tick();  // edge that first samples the new lock level
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("nom_ready_latency", 32'(n), 32'(2 + LS + RC));
      check("nom_sys_reset_low", 32'(sys_reset), 32'(0));
      check("nom_status", 32'({timeout_flag, lock_loss_count}), 32'(0));

      // Three lock losses while running.
      for (int k = 0; k < 3; k++) begin
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
         n = 1;
         while (ready === 1'b1 && n < 10) begin
            tick();
            n++;
         end
         check("loss_ready_drop", 32'(n), 32'(3));
         wait_state(4, 100, "loss_rerun");
      end
      check("loss_count3", 32'(lock_loss_count), 32'(3));

      // Soft reset in RUN: core reset for exactly the release interval.
      soft_reset_req = 1'b1;
      tick();
      soft_reset_req = 1'b0;
      cnt = 0;
      ready_seen = 0;
      n = 0;
      while (ready !== 1'b1 && n < 50) begin
         if (sys_reset === 1'b1) cnt++;
         if (pll_rst === 1'b1) ready_seen++;
         tick();
         n++;
      end
      check("soft_sys_reset_len", 32'(cnt), 32'(RC));
      check("soft_no_pll_rst", 32'(ready_seen), 32'(0));

      // Soft reset in the same cycle the lock drop reaches the FSM.
      loss_before = m_loss;
      pll_locked = 1'b0;
      tick();
      tick();
      soft_reset_req = 1'b1;
      tick();
      soft_reset_req = 1'b0;
      pll_locked = 1'b1;
      check("coinc_state", 32'(state), 32'(0));
      check("coinc_count", 32'(lock_loss_count), 32'(loss_before + 1));

      // Asynchronous reset mid-HOLD and mid-RUN.
      async_reset_in(3, "arst_hold");
      async_reset_in(4, "arst_run");

      // Glitch during qualification.
      do_reset(1);
      pll_locked = 1'b1;
      wait_state(2, 100, "glitch_stab");
      repeat (4) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      n = 0;
      while (state !== 3'd1 && n < 6) begin
         tick();
         n++;
      end
      check("glitch_back_to_wait", 32'(state), 32'(1));
      wait_state(2, 10, "glitch_restab");
      cnt = 1;
      tick();
      while (state === 3'd2 && cnt < 50) begin
         cnt++;
         tick();
      end
      check("glitch_requal_len", 32'(cnt), 32'(LS));
      check("glitch_loss_count", 32'(lock_loss_count), 32'(0));

      // Permanent lack of lock: timeout and periodic PLL reset pulses.
      do_reset(1);
      pll_locked = 1'b0;
      first_to = -1;
      last_rise = -1;
      bad_period = 0;
      ready_seen = 0;
      prev_pll = 1'b1;
      for (int t = 1; t <= 4 * (PRC + TO) + 5; t++) begin
         tick();
         if (timeout_flag === 1'b1 && first_to < 0) first_to = t;
         if (pll_rst === 1'b1 && prev_pll === 1'b0) begin
            if (last_rise >= 0 && t - last_rise != PRC + TO) bad_period++;
            last_rise = t;
         end
         if (ready === 1'b1) ready_seen++;
         prev_pll = pll_rst;
      end
      check("to_first_flag", 32'(first_to), 32'(PRC + TO));
      check("to_last_rise", 32'(last_rise), 32'(4 * (PRC + TO)));
      check("to_bad_periods", 32'(bad_period), 32'(0));
      check("to_ready_never", 32'(ready_seen), 32'(0));

      // Saturation of the lock-loss counter.
      do_reset(1);
      pll_locked = 1'b1;
      for (int k = 0; k < 300; k++) begin
         wait_state(4, 100, "sat_run");
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
         wait_state(0, 10, "sat_loss");
      end
      check("sat_count", 32'(lock_loss_count), 32'(255));
      check("sat_to_clear", 32'(timeout_flag), 32'(0));

      // Randomized lock behaviour and soft reset requests.
      do_reset(1);
      hold_left = 0;
      for (int t = 0; t < 3000; t++) begin
         if (hold_left == 0) begin
            if ($urandom_range(0, 3) != 0) begin
               pll_locked = 1'b1;
               hold_left  = int'($urandom_range(5, 60));
            end else begin
               pll_locked = 1'b0;
               hold_left  = ($urandom_range(0, 7) == 0) ? 80 : int'($urandom_range(1, 6));
            end
         end
         hold_left--;
         soft_reset_req = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 499) == 0) begin
            soft_reset_req = 1'b0;
            do_reset(int'($urandom_range(0, 2)));
         end else begin
            tick();
         end
      end
      soft_reset_req = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
